// File: rtl/reg_bus_pkg.sv
// ============================================================================
// reg_bus_pkg : shared types and constants for the register-bus arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package reg_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    localparam int DEF_NREQ   = 2;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    // Low bit of requester idx's field in a packed per-requester port.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_bus_arbiter_rr_pick.sv
// ============================================================================
// rr_pick  : combinational round-robin picker, searches upward from last+1
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import reg_bus_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // One spare bit so last+1+i never overflows before the wrap subtraction.
    localparam int             c_cw   = IDX_W + 1;
    localparam logic [c_cw-1:0] c_nreq = c_cw'(NREQ);

    logic [c_cw-1:0] w_cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = {1'b0, last_i} + c_cw'(i + 1);
            if (w_cand >= c_nreq) begin
                w_cand = w_cand - c_nreq;
            end
            if (!valid_o && req_i[w_cand[IDX_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_bus_arbiter.sv
// ============================================================================
// reg_bus_arbiter : round-robin arbiter sharing one register bus among masters
// Revision        : 1.0
// ============================================================================
`default_nettype none

module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        we_i,
    input  logic [NREQ*ADDR_W-1:0] addr_i,
    input  logic [NREQ*DATA_W-1:0] wdata_i,
    output logic [NREQ-1:0]        ack_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic [NREQ-1:0]        grant_o,
    output logic                   busy_o,
    output logic                   bus_we_o,
    output logic [ADDR_W-1:0]      bus_addr_o,
    output logic [DATA_W-1:0]      bus_wdata_o,
    input  logic [DATA_W-1:0]      bus_rdata_i
);

    localparam int c_idx_w = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [c_idx_w-1:0]  last_q,  last_d;
    logic                we_q,    we_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [c_idx_w-1:0]  w_pick_idx;
    logic                w_pick_valid;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (c_idx_w)
    ) u_rr_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .idx_o   (w_pick_idx),
        .valid_o (w_pick_valid)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= c_idx_w'(NREQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    grant_d             = '0;
                    grant_d[w_pick_idx] = 1'b1;
                    last_d              = w_pick_idx;
                    we_d                = we_i[w_pick_idx];
                    addr_d  = addr_i[slice_lo(int'(w_pick_idx), ADDR_W) +: ADDR_W];
                    wdata_d = wdata_i[slice_lo(int'(w_pick_idx), DATA_W) +: DATA_W];
                    state_d             = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                // Captured for writes too, so the ack always carries fresh data.
                rdata_d = bus_rdata_i;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign grant_o     = busy_o ? grant_q : '0;
    assign ack_o       = (state_q == ST_ACK) ? grant_q : '0;
    assign bus_we_o    = (state_q == ST_DRIVE) && we_q;
    assign bus_addr_o  = busy_o ? addr_q : '0;
    assign bus_wdata_o = (state_q == ST_DRIVE) ? wdata_q : '0;
    assign rdata_o     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bus_arbiter.sv
// ============================================================================
// tb_reg_bus_arbiter : directed + randomized bench for reg_bus_arbiter
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_reg_bus_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 16;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req   = '0;
    logic [NREQ-1:0]      we    = '0;
    logic [NREQ*AW-1:0]   addr  = '0;
    logic [NREQ*DW-1:0]   wdata = '0;
    logic [NREQ-1:0]      ack, grant;
    logic [DW-1:0]        rdata, bus_wdata, bus_rdata;
    logic                 busy, bus_we;
    logic [AW-1:0]        bus_addr;

    logic [DW-1:0]        sl_mem  [0:63];
    logic [DW-1:0]        ref_mem [0:63];

    int n_pass   = 0;
    int n_total  = 0;
    int last_ref = NREQ - 1;
    int cyc      = 0;
    int ack_cyc  = 0;

    reg_bus_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .ack_o       (ack),
        .rdata_o     (rdata),
        .grant_o     (grant),
        .busy_o      (busy),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_wdata_o (bus_wdata),
        .bus_rdata_i (bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register slave: 64 words below 0x40, everything above reads 0xF001.
    always @(posedge clk) begin
        if (bus_we && bus_addr < 8'h40) sl_mem[bus_addr[5:0]] <= bus_wdata;
    end
    assign bus_rdata = (bus_addr < 8'h40) ? sl_mem[bus_addr[5:0]] : 16'hF001;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return (a < 8'h40) ? ref_mem[a[5:0]] : 16'hF001;
    endfunction

    function automatic int rr_model(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 8'h18;
            1:       return 8'h05;
            2:       return 8'h3F;
            3:       return 8'h40;
            4:       return 8'h41;
            default: return 8'h7E;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input int r, input bit on, input bit w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[r]              = on;
        we[r]               = w;
        addr[r*AW +: AW]    = a;
        wdata[r*DW +: DW]   = d;
    endtask

    task automatic check_idle(input string tag, input logic [DW-1:0] exp_rd);
        check({tag, "_grant"},  32'(grant),     32'h0);
        check({tag, "_ack"},    32'(ack),       32'h0);
        check({tag, "_busy"},   32'(busy),      32'h0);
        check({tag, "_we"},     32'(bus_we),    32'h0);
        check({tag, "_addr"},   32'(bus_addr),  32'h0);
        check({tag, "_wdata"},  32'(bus_wdata), 32'h0);
        check({tag, "_rdata"},  32'(rdata),     32'(exp_rd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("rst", 16'h0);
        rst_n    = 1'b1;
        last_ref = NREQ - 1;
    endtask

    // Called in an IDLE cycle before the sampling edge; returns at the
    // falling edge of the following IDLE cycle.
    task automatic txn(input int w, input bit drop, input string tag,
                       output logic [DW-1:0] rd);
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ed, er;
        logic [31:0]   oh;
        ea  = addr[w*AW +: AW];
        ewe = we[w];
        ed  = wdata[w*DW +: DW];
        er  = ref_read(ea);
        oh  = 32'h1 << w;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_drv_grant"}, 32'(grant),     oh);
        check({tag, "_drv_busy"},  32'(busy),      32'h1);
        check({tag, "_drv_we"},    32'(bus_we),    32'(ewe));
        check({tag, "_drv_addr"},  32'(bus_addr),  32'(ea));
        check({tag, "_drv_wdata"}, 32'(bus_wdata), 32'(ed));
        check({tag, "_drv_ack"},   32'(ack),       32'h0);
        if (ewe && ea < 8'h40) ref_mem[ea[5:0]] = ed;
        if (drop) req[w] = 1'b0;
        @(negedge clk);
        check({tag, "_ack_ack"},   32'(ack),       oh);
        check({tag, "_ack_grant"}, 32'(grant),     oh);
        check({tag, "_ack_rdata"}, 32'(rdata),     32'(er));
        check({tag, "_ack_we"},    32'(bus_we),    32'h0);
        check({tag, "_ack_addr"},  32'(bus_addr),  32'(ea));
        rd      = rdata;
        ack_cyc = cyc;
        @(negedge clk);
        check_idle({tag, "_idle"}, er);
        last_ref = w;
    endtask

    initial begin
        logic [DW-1:0] rd;
        int            prev_ack;
        int            w;

        for (int a = 0; a < 64; a++) begin
            sl_mem[a]  = (a == 24) ? 16'h5678 : {8'hA5, 8'(a)};
            ref_mem[a] = sl_mem[a];
        end

        do_reset();

        // Basic read / unmapped read / write / read-back from requester 0.
        set_req(0, 1, 0, 8'h18, 16'h0);
        txn(0, 0, "rd18_init", rd);
        check("rd18_init_val", 32'(rd), 32'h5678);
        set_req(0, 1, 0, 8'h40, 16'h0);
        txn(0, 0, "rd40", rd);
        check("rd40_val", 32'(rd), 32'hF001);
        set_req(0, 1, 1, 8'h18, 16'h1234);
        txn(0, 0, "wr18", rd);
        set_req(0, 1, 0, 8'h18, 16'h0);
        txn(0, 0, "rd18_back", rd);
        check("rd18_back_val", 32'(rd), 32'h1234);
        req = '0;
        repeat (3) begin
            @(negedge clk);
            check("noreq_busy", 32'(busy), 32'h0);
        end

        // Two requesters held from reset alternate 0,1,0,1 with acks 3 apart.
        set_req(0, 1, 0, 8'h05, 16'h0);
        set_req(1, 1, 0, 8'h06, 16'h0);
        do_reset();
        prev_ack = 0;
        for (int i = 0; i < 4; i++) begin
            txn(i % 2, 0, "alt", rd);
            if (i > 0) check("alt_spacing", 32'(ack_cyc - prev_ack), 32'd3);
            prev_ack = ack_cyc;
        end

        // Wrap-around: 4'b1001 after reset grants 0 then 3 then 0.
        req = '0;
        set_req(0, 1, 0, 8'h07, 16'h0);
        set_req(3, 1, 0, 8'h08, 16'h0);
        do_reset();
        txn(0, 0, "wrap0", rd);
        txn(3, 0, "wrap3", rd);
        txn(0, 0, "wrap0b", rd);

        // Reset during DRIVE of a read aborts it without an ack.
        req = '0;
        set_req(0, 1, 0, 8'h18, 16'h0);
        @(posedge clk);
        @(negedge clk);
        check("abort_drive_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_idle("abort", 16'h0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_ack", 32'(ack), 32'h0);
        end
        rst_n    = 1'b1;
        last_ref = NREQ - 1;
        txn(0, 0, "after_abort", rd);
        check("after_abort_val", 32'(rd), 32'h1234);

        // Requester drops req after grant: one ack, no follow-up transaction.
        txn(0, 1, "drop", rd);
        repeat (3) begin
            @(negedge clk);
            check("drop_no_busy", 32'(busy), 32'h0);
            check("drop_no_ack",  32'(ack),  32'h0);
        end

        // Randomized traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!req[r] && $urandom_range(0, 1) == 1)
                    set_req(r, 1, 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
            end
            if (req == '0)
                set_req(int'($urandom_range(0, NREQ - 1)), 1, 1'($urandom_range(0, 1)),
                        pick_addr(), 16'($urandom));
            w = rr_model(req, last_ref);
            txn(w, 0, "rand", rd);
            req[w] = 1'b0;
        end
        req = '0;
        @(negedge clk);
        check("final_idle_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
